// File: rtl/tlight_pkg.sv
// Shared types and default phase durations for the traffic-light sequencer.
package tlight_pkg;

    // Encoding matches the display stage's color mux order.
    typedef enum logic [1:0] {
        Red    = 2'd0,
        Yellow = 2'd1,
        Green  = 2'd2
    } phase_t;

    localparam int unsigned DefRedFrames      = 240;
    localparam int unsigned DefGreenFrames    = 240;
    localparam int unsigned DefYellowFrames   = 60;
    localparam int unsigned DefGreenMinFrames = 60;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tlight_seq.sv
// Frame-tick driven RED -> GREEN -> YELLOW phase sequencer with a latched pedestrian request
// that can shorten GREEN down to GREEN_MIN_FRAMES.
module tlight_seq
    import tlight_pkg::*;
#(
    parameter int unsigned RED_FRAMES       = DefRedFrames,
    parameter int unsigned GREEN_FRAMES     = DefGreenFrames,
    parameter int unsigned YELLOW_FRAMES    = DefYellowFrames,
    parameter int unsigned GREEN_MIN_FRAMES = DefGreenMinFrames
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       ped_req,
    output logic [1:0] color_sel,
    output logic       phase_start,
    output logic       ped_ack,
    output logic       ped_pending
);

    localparam int unsigned MaxFrames =
        max2(max2(RED_FRAMES, GREEN_FRAMES), YELLOW_FRAMES);
    localparam int unsigned CntW = $clog2(MaxFrames + 1);

    localparam logic [CntW-1:0] RedLast      = CntW'(RED_FRAMES - 1);
    localparam logic [CntW-1:0] GreenLast    = CntW'(GREEN_FRAMES - 1);
    localparam logic [CntW-1:0] YellowLast   = CntW'(YELLOW_FRAMES - 1);
    localparam logic [CntW-1:0] GreenMinLast = CntW'(GREEN_MIN_FRAMES - 1);

    phase_t          state_q;
    phase_t          state_next;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] term;
    logic            phase_done;
    logic            pend_next;

    always_comb begin
        term       = RedLast;
        state_next = Red;
        unique case (state_q)
            Red: begin
                term       = RedLast;
                state_next = Green;
            end
            Green: begin
                term       = GreenLast;
                state_next = Yellow;
            end
            Yellow: begin
                term       = YellowLast;
                state_next = Red;
            end
            default: begin
                term       = RedLast;
                state_next = Red;
            end
        endcase
        // A pending request may end GREEN once its minimum length is reached.
        phase_done = (count_q == term) ||
                     ((state_q == Green) && ped_pending && (count_q >= GreenMinLast));
        pend_next  = ped_pending | ped_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= Red;
            count_q     <= '0;
            ped_pending <= 1'b0;
            phase_start <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            phase_start <= 1'b0;
            ped_ack     <= 1'b0;
            ped_pending <= pend_next;
            if (frame_tick && phase_done) begin
                state_q     <= state_next;
                count_q     <= '0;
                phase_start <= 1'b1;
                // Requests arriving in the same cycle as RED entry are served too.
                if (state_next == Red && pend_next) begin
                    ped_ack     <= 1'b1;
                    ped_pending <= 1'b0;
                end
            end else if (frame_tick) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign color_sel = state_q;

endmodule

// File: tb/tb_tlight_seq.sv
// Directed checks of tlight_seq phase sequencing, pedestrian latch and reset behaviour.
module tb_tlight_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       ped_req;
    logic [1:0] color_sel;
    logic       phase_start;
    logic       ped_ack;
    logic       ped_pending;

    int n_checks = 0;
    int n_pass   = 0;

    tlight_seq #(
        .RED_FRAMES       (3),
        .GREEN_FRAMES     (4),
        .YELLOW_FRAMES    (2),
        .GREEN_MIN_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .ped_req     (ped_req),
        .color_sel   (color_sel),
        .phase_start (phase_start),
        .ped_ack     (ped_ack),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input logic tick, input logic req);
        frame_tick = tick;
        ped_req    = req;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        ped_req    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    int exp_col[9] = '{0, 0, 2, 2, 2, 2, 1, 1, 0};
    int exp_ps[9]  = '{0, 0, 1, 0, 0, 0, 1, 0, 1};
    int acks;
    int bad_col;
    int changes;
    logic [1:0] held;

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        ped_req    = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0);  // tick during reset is ignored
        reset = 1'b0;
        check("rst_color", color_sel, 0);
        check("rst_pending", ped_pending, 0);
        check("rst_phase_start", phase_start, 0);
        check("rst_ack", ped_ack, 0);

        // 1: nominal sequence, tick every 10 cycles
        for (int k = 0; k < 9; k++) begin
            idle(9);
            step(1'b1, 1'b0);
            check($sformatf("t1_color_%0d", k), color_sel, exp_col[k]);
            check($sformatf("t1_ps_%0d", k), phase_start, exp_ps[k]);
            check($sformatf("t1_ack_%0d", k), ped_ack, 0);
            idle(1);
            check($sformatf("t1_ps_clr_%0d", k), phase_start, 0);
        end

        // 2: request during RED shortens GREEN to 2 ticks
        step(1'b0, 1'b1);
        check("t2_pending", ped_pending, 1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        check("t2_green", color_sel, 2);
        check("t2_pending_green", ped_pending, 1);
        step(1'b1, 1'b0);
        check("t2_green_1", color_sel, 2);
        step(1'b1, 1'b0);
        check("t2_yellow", color_sel, 1);
        check("t2_ack_early", ped_ack, 0);
        step(1'b1, 1'b0);
        check("t2_yellow_1", color_sel, 1);
        step(1'b1, 1'b0);
        check("t2_red", color_sel, 0);
        check("t2_ack", ped_ack, 1);
        check("t2_pending_clr", ped_pending, 0);
        idle(1);
        check("t2_ack_clr", ped_ack, 0);

        // 3: late request in GREEN ends on the 4th tick
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0);
        check("t3_green_3", color_sel, 2);
        step(1'b0, 1'b1);
        check("t3_pending", ped_pending, 1);
        step(1'b1, 1'b0);
        check("t3_yellow", color_sel, 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("t3_red", color_sel, 0);
        check("t3_ack", ped_ack, 1);

        // 4: request in the same cycle as YELLOW's final tick
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
        check("t4_yellow", color_sel, 1);
        check("t4_no_ack", ped_ack, 0);
        step(1'b1, 1'b1);
        check("t4_red", color_sel, 0);
        check("t4_ack", ped_ack, 1);
        check("t4_pending", ped_pending, 0);
        idle(1);
        check("t4_ack_clr", ped_ack, 0);
        check("t4_pending_1", ped_pending, 0);

        // 5: reset mid-GREEN with a pending request
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        check("t5_green", color_sel, 2);
        step(1'b0, 1'b1);
        check("t5_pending", ped_pending, 1);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        check("t5_color", color_sel, 0);
        check("t5_pending_clr", ped_pending, 0);
        acks = 0;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0);
            acks += int'(ped_ack);
            idle(2);
            acks += int'(ped_ack);
        end
        check("t5_red_held", color_sel, 0);
        step(1'b1, 1'b0);
        acks += int'(ped_ack);
        check("t5_green_again", color_sel, 2);
        check("t5_no_ack", acks, 0);

        // 6: long idle keeps color and count
        held    = color_sel;
        changes = 0;
        for (int k = 0; k < 1000; k++) begin
            step(1'b0, 1'b0);
            if (color_sel !== held) changes++;
        end
        check("t6_idle_const", changes, 0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        check("t6_green_kept", color_sel, 2);
        step(1'b1, 1'b0);
        check("t6_yellow", color_sel, 1);

        // 6b: random ticks and requests, color 3 must never appear
        bad_col = 0;
        for (int t = 0; t < 10000; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom_range(0, 7) == 0));
                if (color_sel == 2'd3) bad_col++;
            end
            step(1'b1, 1'($urandom_range(0, 7) == 0));
            if (color_sel == 2'd3) bad_col++;
        end
        check("t6_never_3", bad_col, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlight_seq.md
# tlight_seq

Phase sequencer that decides which traffic-light color the VGA display stage shows. It counts frame ticks from the display's sync timing, steps RED → GREEN → YELLOW → RED with per-phase durations, and shortens GREEN on a latched pedestrian request. Its `color_sel` output drives the display stage's color mux directly, so the color changes only on frame boundaries.

## Interface
Parameters:
- `RED_FRAMES`, default 240: RED length in frame ticks (4 s at 60 Hz).
- `GREEN_FRAMES`, default 240: nominal GREEN length in frame ticks.
- `YELLOW_FRAMES`, default 60: YELLOW length in frame ticks.
- `GREEN_MIN_FRAMES`, default 60: minimum GREEN length when a pedestrian request is pending.
- Constraints: all four ≥ 1; `GREEN_MIN_FRAMES` ≤ `GREEN_FRAMES`.
- Counter width is `$clog2(max duration + 1)`; it is derived, not a port parameter.

Ports:
- `clk`  in  1: clock. One clock domain only.
- `reset`  in  1: synchronous, active-high.
- `frame_tick`  in  1: one-cycle pulse once per frame (start of frame, from the display's sync timing).
- `ped_req`  in  1: pedestrian request, sampled every cycle; a 1-cycle pulse is sufficient.
- `color_sel`  out  2: 0 = RED, 1 = YELLOW, 2 = GREEN; 3 is never driven.
- `phase_start`  out  1: one-cycle pulse in the first cycle of each new phase.
- `ped_ack`  out  1: one-cycle pulse when a pending request is served (on entry to RED).
- `ped_pending`  out  1: the request latch.

## Operation
- States: RED, GREEN, YELLOW. `color_sel` equals the state encoding.
- Reset values: state = RED, `color_sel` = 0, count = 0, `ped_pending` = 0, `phase_start` = 0, `ped_ack` = 0.
- Count: increments only on cycles with `frame_tick`; otherwise it holds.
- Transition rule: on a `frame_tick` cycle where count == DUR−1 for the current phase:
  - move to the next phase;
  - clear count to 0;
  - assert `phase_start` in the next cycle.
  - Phase order: RED → GREEN → YELLOW → RED.
- Early GREEN exit: in GREEN, on a `frame_tick` cycle where `ped_pending` = 1 and count ≥ `GREEN_MIN_FRAMES`−1, go to YELLOW even if count < `GREEN_FRAMES`−1.
- Request latch:
  - Any cycle with `ped_req` = 1 sets `ped_pending`, in every state.
  - Entering RED with `ped_pending` = 1: clear `ped_pending` and pulse `ped_ack`.
  - Entering RED with `ped_pending` = 0: no `ped_ack`.
- Simultaneous events:
  - `ped_req` in the same cycle as the YELLOW→RED transition counts as served: `ped_ack` pulses and the latch ends at 0.
  - `ped_req` while in RED stays latched and is acknowledged at the next RED entry; it also shortens the intervening GREEN.
- Boundaries:
  - DUR = 1 means the phase lasts exactly one tick.
  - Count never exceeds DUR−1, so there is no wrap.
  - `frame_tick` during reset is ignored.
  - Reset mid-phase returns to RED with count 0 in the next cycle and discards any pending request without `ped_ack`.

## Timing
- All outputs are registered.
- Latency: 1 cycle from the deciding `frame_tick` cycle to the new `color_sel`, the `phase_start` pulse and the `ped_ack` pulse.
- `ped_pending` goes high 1 cycle after `ped_req`.
- Phase lengths:
  - RED, YELLOW, and GREEN without a request are exactly DUR frame ticks after entry.
  - GREEN with a request pending by its `GREEN_MIN_FRAMES`-th tick is exactly `GREEN_MIN_FRAMES` ticks.
  - A request arriving later in GREEN ends GREEN on the next tick.
- After reset, the first RED lasts `RED_FRAMES` ticks and no `phase_start` is emitted for it.

## Structure
- `tlight_pkg`:
  - `phase_t` enum (RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2), matching the display mux's color order;
  - a default-duration localparam set.
- Single module with no sub-modules: a state register, one duration counter with a per-state terminal-value mux, and the request latch.

## Test plan
Small parameters: RED = 3, GREEN = 4, YELLOW = 2, GREEN_MIN = 2.
1. Reset, ticks every 10 cycles, no requests → `color_sel` runs 0 for 3 ticks, 2 for 4, 1 for 2, 0; `phase_start` pulses once at each change, 1 cycle after the tick.
2. `ped_req` pulse during RED → `ped_pending` = 1; GREEN lasts 2 ticks; YELLOW 2; `ped_ack` pulses on RED entry and `ped_pending` returns to 0.
3. `ped_req` after GREEN's 3rd tick → YELLOW on the next (4th) tick, same as nominal; `ped_ack` follows at RED entry.
4. `ped_req` in the same cycle as YELLOW's final tick → exactly one `ped_ack` the next cycle; `ped_pending` = 0 afterwards.
5. Reset asserted mid-GREEN with a request pending → next cycle `color_sel` = 0, `ped_pending` = 0, and no `ped_ack` ever pulses for it.
6. No `frame_tick` for 1000 cycles → `color_sel` is constant and count unchanged; `color_sel` is never 3 across a 10 000-tick random run with random `ped_req`.
